ahb_mgr_hold_stage: RTL

// - Per-manager input stage between one AHB manager port and the multi-manager arbiter/mux; one instance per manager.
// - Captures each address phase into a hold register and raises req to the arbiter.
// - Stalls the manager with HREADY low until the transfer is issued on the shared bus and completes.
// - Owns its data phase and forwards HRDATA/HRESP/HREADY back to the manager.

---
 rtl/ahb_mgr_hold_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ahb_mgr_hold_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_mgr_hold_stage
//  Purpose  : Per-manager input stage in front of a multi-manager AHB
//             arbiter/mux. Each manager address phase is captured into a
//             hold register. The stage then requests the shared bus, replays
//             the transfer as a NONSEQ/SINGLE once granted, and stalls the
//             manager until the shared-bus data phase completes. Data phase
//             signals (HWDATA, HRDATA, HRESP, HREADY) pass through only while
//             this stage owns the shared-bus data phase.
//  Ports    :
//    HCLK, HRESETn             clock, asynchronous active-low reset
//    m_H* (ADDR/TRANS/WRITE/SIZE/BURST/WDATA in; READY/RESP/RDATA out)
//                              manager-facing AHB port
//    req (out), grant (in)     arbiter handshake
//    b_H* (ADDR/TRANS/WRITE/SIZE/BURST/WDATA out; READY/RESP/RDATA in)
//                              shared-bus AHB port
//  Revision : 1.0  initial release
// ============================================================================
module ahb_mgr_hold_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    // manager side
    input  logic [ADDR_WIDTH-1:0] m_HADDR,
    input  logic [1:0]            m_HTRANS,
    input  logic                  m_HWRITE,
    input  logic [2:0]            m_HSIZE,
    input  logic [2:0]            m_HBURST,
    input  logic [DATA_WIDTH-1:0] m_HWDATA,
    output logic                  m_HREADY,
    output logic                  m_HRESP,
    output logic [DATA_WIDTH-1:0] m_HRDATA,
    // arbiter handshake
    output logic                  req,
    input  logic                  grant,
    // shared-bus side
    output logic [ADDR_WIDTH-1:0] b_HADDR,
    output logic [1:0]            b_HTRANS,
    output logic                  b_HWRITE,
    output logic [2:0]            b_HSIZE,
    output logic [2:0]            b_HBURST,
    output logic [DATA_WIDTH-1:0] b_HWDATA,
    input  logic                  b_HREADY,
    input  logic                  b_HRESP,
    input  logic [DATA_WIDTH-1:0] b_HRDATA
);

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] c_HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PEND  = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q,  size_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  w_capture;

    // Burst type and HTRANS[0] are not needed: every transfer is replayed as
    // an independent single, because gap cycles are inserted between beats.
    logic                  w_unused;
    assign w_unused = ^{m_HBURST, m_HTRANS[0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_EMPTY;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'b000;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
        rdata_d   = rdata_q;

        m_HREADY  = 1'b1;
        m_HRESP   = 1'b0;
        m_HRDATA  = rdata_q;
        req       = 1'b0;

        b_HADDR   = '0;
        b_HTRANS  = c_HTRANS_IDLE;
        b_HWRITE  = 1'b0;
        b_HSIZE   = 3'b000;
        b_HBURST  = c_HBURST_SINGLE;
        b_HWDATA  = '0;

        unique case (state_q)
            ST_EMPTY: begin
                // Manager sees a zero-wait-state slave; nothing outstanding.
            end
            ST_PEND: begin
                m_HREADY = 1'b0;
                req      = 1'b1;
                // The bus address phase is only valid when the shared bus is
                // ready, i.e. the previous owner's data phase has finished.
                if (grant && b_HREADY) begin
                    b_HADDR  = addr_q;
                    b_HTRANS = c_HTRANS_NONSEQ;
                    b_HWRITE = write_q;
                    b_HSIZE  = size_q;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                // Grant is deliberately ignored here: once the address phase
                // is issued, this stage owns the data phase until it ends.
                b_HWDATA = m_HWDATA;
                m_HRDATA = b_HRDATA;
                m_HRESP  = b_HRESP;
                m_HREADY = b_HREADY;
                rdata_d  = b_HRDATA;
                if (b_HREADY) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // A manager address phase is accepted whenever the manager sees
        // HREADY high; this overrides the DATA -> EMPTY exit so a follow-on
        // transfer presented during completion goes straight to PEND.
        w_capture = m_HREADY && m_HTRANS[1];
        if (w_capture) begin
            addr_d  = m_HADDR;
            write_d = m_HWRITE;
            size_d  = m_HSIZE;
            state_d = ST_PEND;
        end
    end

endmodule
`default_nettype wire
